ula_alu: RTL and testbench



---
 rtl/ula_alu.sv | 127 ++++++++++++
 tb/tb_ula_alu.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ula_alu.sv
// 32-bit EX-stage ALU: result and carry/overflow are captured on the falling clock edge.
// zero and neg are decoded from the registered result.
module ula_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       opcode,
  output logic [WIDTH-1:0] Out,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             overflow
);

  typedef enum logic [4:0] {
    OP_ADD   = 5'b00000, OP_ADDC  = 5'b00001, OP_INC   = 5'b00010, OP_SUBB  = 5'b00011,
    OP_SUB   = 5'b00100, OP_DEC   = 5'b00101, OP_LSL   = 5'b00110, OP_ASR   = 5'b00111,
    OP_ZERO  = 5'b01000, OP_ONES  = 5'b01001, OP_PASSA = 5'b01010, OP_NOTA  = 5'b01011,
    OP_AND   = 5'b01100, OP_NAANDB = 5'b01101, OP_AANDNB = 5'b01110, OP_NAND = 5'b01111,
    OP_OR    = 5'b10000, OP_NAORB = 5'b10001, OP_AORNB = 5'b10010, OP_NOR   = 5'b10011,
    OP_XOR   = 5'b10100, OP_XNOR  = 5'b10101, OP_PASSB = 5'b10110, OP_LSR   = 5'b10111
  } alu_op_e;

  localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] ONES_X = {1'b0, {WIDTH{1'b1}}};

  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   sum;
  logic             sa, sb, sr;

  always_comb begin
    out_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    sum     = '0;
    sa      = A[WIDTH-1];
    sb      = B[WIDTH-1];
    sr      = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDC: begin
        sum     = {1'b0, A} + {1'b0, B} + ((opcode == OP_ADDC) ? ONE_X : '0);
        out_d   = sum[WIDTH-1:0];
        sr      = sum[WIDTH-1];
        carry_d = sum[WIDTH];
        ovf_d   = (sa == sb) && (sr != sa);
      end
      OP_INC: begin
        sum     = {1'b0, A} + ONE_X;
        out_d   = sum[WIDTH-1:0];
        sr      = sum[WIDTH-1];
        carry_d = sum[WIDTH];
        ovf_d   = !sa && sr;
      end
      // Subtracts are done as A + ~subtrahend + cin; a missing carry-out is the borrow.
      OP_SUBB, OP_SUB: begin
        sum     = {1'b0, A} + {1'b0, ~B} + ((opcode == OP_SUB) ? ONE_X : '0);
        out_d   = sum[WIDTH-1:0];
        sr      = sum[WIDTH-1];
        carry_d = !sum[WIDTH];
        ovf_d   = (sa != sb) && (sr != sa);
      end
      OP_DEC: begin
        sum     = {1'b0, A} + ONES_X;
        out_d   = sum[WIDTH-1:0];
        sr      = sum[WIDTH-1];
        carry_d = !sum[WIDTH];
        ovf_d   = sa && !sr;
      end
      OP_LSL: begin
        out_d   = {A[WIDTH-2:0], 1'b0};
        carry_d = A[WIDTH-1];
      end
      OP_ASR: begin
        out_d   = {A[WIDTH-1], A[WIDTH-1:1]};
        carry_d = A[0];
      end
      OP_LSR: begin
        out_d   = {1'b0, A[WIDTH-1:1]};
        carry_d = A[0];
      end
      OP_ZERO:    out_d = '0;
      OP_ONES:    out_d = '1;
      OP_PASSA:   out_d = A;
      OP_NOTA:    out_d = ~A;
      OP_AND:     out_d = A & B;
      OP_NAANDB:  out_d = ~A & B;
      OP_AANDNB:  out_d = A & ~B;
      OP_NAND:    out_d = ~(A & B);
      OP_OR:      out_d = A | B;
      OP_NAORB:   out_d = ~A | B;
      OP_AORNB:   out_d = A | ~B;
      OP_NOR:     out_d = ~(A | B);
      OP_XOR:     out_d = A ^ B;
      OP_XNOR:    out_d = ~(A ^ B);
      OP_PASSB:   out_d = B;
      default: begin
        out_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Out      = out_q;
  assign zero     = (out_q == '0);
  assign neg      = out_q[WIDTH-1];
  assign carry    = carry_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ula_alu.sv
// Directed + randomized bench for ula_alu, checked against a wide-integer arithmetic model.
module tb_ula_alu;

  logic        clock;
  logic        reset_n;
  logic [31:0] A, B;
  logic [4:0]  opcode;
  logic [31:0] Out;
  logic        zero, neg, carry, overflow;

  int checks = 0;
  int errors = 0;

  ula_alu #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .A(A), .B(B), .opcode(opcode),
    .Out(Out), .zero(zero), .neg(neg), .carry(carry), .overflow(overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (A=%h B=%h op=%b)", tag, obs, exp, A, B, opcode);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] r, input logic c, input logic v);
    check({tag, ".out"}, Out, r);
    check({tag, ".zero"}, {31'b0, zero}, {31'b0, (r == 32'h0)});
    check({tag, ".neg"}, {31'b0, neg}, {31'b0, r[31]});
    check({tag, ".carry"}, {31'b0, carry}, {31'b0, c});
    check({tag, ".ovf"}, {31'b0, overflow}, {31'b0, v});
  endtask

  // Reference: exact 64-bit integer arithmetic, flags from range checks.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                                output logic [31:0] r, output logic c, output logic v);
    longint unsigned ua, ub, u, subtr;
    longint sa, sb, s;
    bit arith;
    ua = 64'(a); ub = 64'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    u = 0; s = 0; subtr = 0; arith = 1'b0;
    r = 32'h0; c = 1'b0; v = 1'b0;
    case (op)
      5'd0: begin u = ua + ub;     s = sa + sb;     arith = 1; c = (u > 64'hFFFF_FFFF); end
      5'd1: begin u = ua + ub + 1; s = sa + sb + 1; arith = 1; c = (u > 64'hFFFF_FFFF); end
      5'd2: begin u = ua + 1;      s = sa + 1;      arith = 1; c = (u > 64'hFFFF_FFFF); end
      5'd3: begin subtr = ub + 1; u = ua - subtr; s = sa - sb - 1; arith = 1; c = (ua < subtr); end
      5'd4: begin subtr = ub;     u = ua - subtr; s = sa - sb;     arith = 1; c = (ua < subtr); end
      5'd5: begin subtr = 1;      u = ua - subtr; s = sa - 1;      arith = 1; c = (ua < subtr); end
      5'd6:  begin r = a << 1; c = a[31]; end
      5'd7:  begin r = 32'($signed(a) >>> 1); c = a[0]; end
      5'd8:  r = 32'h0;
      5'd9:  r = 32'hFFFF_FFFF;
      5'd10: r = a;
      5'd11: r = ~a;
      5'd12: r = a & b;
      5'd13: r = ~a & b;
      5'd14: r = a & ~b;
      5'd15: r = ~(a & b);
      5'd16: r = a | b;
      5'd17: r = ~a | b;
      5'd18: r = a | ~b;
      5'd19: r = ~(a | b);
      5'd20: r = a ^ b;
      5'd21: r = ~(a ^ b);
      5'd22: r = b;
      5'd23: begin r = a >> 1; c = a[0]; end
      default: r = 32'h0;
    endcase
    if (arith) begin
      r = u[31:0];
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
  endfunction

  // Drive just after a posedge; the DUT captures on the following negedge; sample on the next posedge.
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    A = a; B = b; opcode = op;
    @(posedge clock); #1;
  endtask

  task automatic step_model(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] op);
    logic [31:0] r; logic c, v;
    model(a, b, op, r, c, v);
    step(a, b, op);
    check_all(tag, r, c, v);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    A = 32'd5; B = 32'd3; opcode = 5'b00000;
    #1;
    check_all("reset_imm", 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check_all("reset_hold", 32'h0, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_all("release_add", 32'd8, 1'b0, 1'b0);

    step_model("t2_add_ovf", 32'h7FFF_FFFF, 32'h1, 5'b00000);
    check_all("t2_direct", 32'h8000_0000, 1'b0, 1'b1);
    step(32'hFFFF_FFFF, 32'h0, 5'b00010);
    check_all("t3_inc_wrap", 32'h0, 1'b1, 1'b0);
    step(32'h0, 32'h0, 5'b00101);
    check_all("t3_dec_wrap", 32'hFFFF_FFFF, 1'b1, 1'b0);
    step(32'd10, 32'd10, 5'b00100);
    check_all("t4_sub_eq", 32'h0, 1'b0, 1'b0);
    step(32'd3, 32'd5, 5'b00100);
    check_all("t4_sub_borrow", 32'hFFFF_FFFE, 1'b1, 1'b0);
    step(32'hF0F0_F0F0, 32'hFF00_FF00, 5'b01100);
    check_all("t5_and", 32'hF000_F000, 1'b0, 1'b0);
    step(32'hF0F0_F0F0, 32'hFF00_FF00, 5'b10100);
    check_all("t5_xor", 32'h0FF0_0FF0, 1'b0, 1'b0);
    step(32'hF0F0_F0F0, 32'hFF00_FF00, 5'b01011);
    check_all("t5_not", 32'h0F0F_0F0F, 1'b0, 1'b0);
    step(32'h8000_0001, 32'h0, 5'b00111);
    check_all("t6_asr", 32'hC000_0000, 1'b1, 1'b0);
    step(32'h8000_0001, 32'h0, 5'b10111);
    check_all("t6_lsr", 32'h4000_0000, 1'b1, 1'b0);
    step(32'h8000_0001, 32'h0, 5'b00110);
    check_all("t6_lsl", 32'h0000_0002, 1'b1, 1'b0);
    step(32'h8000_0001, 32'hFFFF_FFFF, 5'b11010);
    check_all("t6_reserved", 32'h0, 1'b0, 1'b0);
    step_model("subb_ovf", 32'h8000_0000, 32'h0, 5'b00011);
    step_model("dec_ovf", 32'h8000_0000, 32'h0, 5'b00101);

    // Inputs changing between negedges must not disturb the held result.
    step(32'd1, 32'd2, 5'b00000);
    #1 A = 32'd100; B = 32'd200;
    #2 check("hold_between", Out, 32'd3);

    // Reset asserted mid-cycle clears at once.
    #1 reset_n = 1'b0;
    #1 check_all("mid_reset", 32'h0, 1'b0, 1'b0);
    @(posedge clock); #1;
    check_all("mid_reset_hold", 32'h0, 1'b0, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      step_model("rand", pick(), pick(), 5'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
